// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-to-decode handshake: head of the fetch buffer offered with valid/ready.
// master = fetch sequencer, slave = decode stage.
interface imem_fetch_ctrl_if;
    logic        IfValid;
    logic        IfReady;
    logic [31:0] IfInstr;
    logic [31:0] IfPC;
    logic [31:0] IfPCPlus4;

    modport master (
        output IfValid,
        output IfInstr,
        output IfPC,
        output IfPCPlus4,
        input  IfReady
    );

    modport slave (
        input  IfValid,
        input  IfInstr,
        input  IfPC,
        input  IfPCPlus4,
        output IfReady
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: PC, 2-entry fetch buffer, redirect/halt handling.
// Optional: define ALIGN_CHECK_EN to trap misaligned redirect targets (sticky Fault).
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    output logic [31:0]               Address,
    input  logic [31:0]               Instruction,
    input  logic                      RedirectValid,
    input  logic [31:0]               RedirectTarget,
    imem_fetch_ctrl_if.master         dec,
    output logic                      Halted,
    output logic                      Fault
);

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] b0_instr_q, b0_instr_d;
    logic [31:0] b0_pc_q, b0_pc_d;
    logic [31:0] b1_instr_q, b1_instr_d;
    logic [31:0] b1_pc_q, b1_pc_d;
    logic        fault_q, fault_d;

    logic        pop;
    logic        redirect;
    logic        redirect_bad;
    logic [31:0] redirect_pc;
    logic        capture;
    logic [1:0]  count_after;

`ifdef ALIGN_CHECK_EN
    assign redirect     = RedirectValid && !fault_q;
    assign redirect_bad = (RedirectTarget[1:0] != 2'b00);
    assign redirect_pc  = RedirectTarget;
`else
    logic unused_target_lsb;
    assign unused_target_lsb = ^RedirectTarget[1:0];
    assign redirect          = RedirectValid;
    assign redirect_bad      = 1'b0;
    assign redirect_pc       = {RedirectTarget[31:2], 2'b00};
`endif

    assign pop         = (count_q != 2'd0) && dec.IfReady;
    assign count_after = count_q - {1'b0, pop};

    // Entry 0 is always the head; a pop shifts entry 1 down before any capture lands.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        b0_instr_d = b0_instr_q;
        b0_pc_d    = b0_pc_q;
        b1_instr_d = b1_instr_q;
        b1_pc_d    = b1_pc_q;
        fault_d    = fault_q;
        capture    = 1'b0;

        if (redirect) begin
            count_d = 2'd0;
            pc_d    = redirect_pc;
            if (redirect_bad) begin
                fault_d = 1'b1;
                state_d = ST_HALT;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            if (pop) begin
                b0_instr_d = b1_instr_q;
                b0_pc_d    = b1_pc_q;
            end
            capture = (state_q == ST_RUN) && (count_after != 2'd2);
            if (capture) begin
                if (count_after == 2'd0) begin
                    b0_instr_d = Instruction;
                    b0_pc_d    = pc_q;
                end else begin
                    b1_instr_d = Instruction;
                    b1_pc_d    = pc_q;
                end
                pc_d = pc_q + 32'd4;
                if (Instruction == HALT_WORD) begin
                    state_d = ST_HALT;
                end
            end
            count_d = count_after + {1'b0, capture};
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            count_q    <= 2'd0;
            b0_instr_q <= '0;
            b0_pc_q    <= '0;
            b1_instr_q <= '0;
            b1_pc_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            b0_instr_q <= b0_instr_d;
            b0_pc_q    <= b0_pc_d;
            b1_instr_q <= b1_instr_d;
            b1_pc_q    <= b1_pc_d;
            fault_q    <= fault_d;
        end
    end

    assign Address       = pc_q;
    assign dec.IfValid   = (count_q != 2'd0);
    assign dec.IfInstr   = b0_instr_q;
    assign dec.IfPC      = b0_pc_q;
    assign dec.IfPCPlus4 = b0_pc_q + 32'd4;
    assign Halted        = (state_q == ST_HALT);
    assign Fault         = fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: queue-level reference model, directed plan then random.
module tb_imem_fetch_ctrl;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct packed {
        logic        chk;
        logic        valid;
        ent_t        head;
        logic [31:0] pc;
        logic        halted;
        logic        fault;
        logic        zero_head;
    } st_t;

    logic        Clk = 1'b1;
    logic        Reset_n;
    logic [31:0] Address;
    logic [31:0] Instruction;
    logic        RedirectValid;
    logic [31:0] RedirectTarget;
    logic        Halted;
    logic        Fault;

    logic [31:0] halt_addr;
    logic        use_seq;
    logic        running = 1'b1;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    ent_t mq[$];
    ent_t exp_q[$];
    st_t  st_q[$];

    logic [31:0] m_pc;
    logic        m_halted;
    logic        m_fault;
    logic        m_zero;
    logic        m_known = 1'b0;

    imem_fetch_ctrl_if dec ();

    imem_fetch_ctrl #(
        .RESET_PC (RESET_PC),
        .HALT_WORD(HALT_WORD)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .Address       (Address),
        .Instruction   (Instruction),
        .RedirectValid (RedirectValid),
        .RedirectTarget(RedirectTarget),
        .dec           (dec.master),
        .Halted        (Halted),
        .Fault         (Fault)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] ha,
                                             input logic seq);
        if (a == ha) return HALT_WORD;
        if (seq && a < 32'h10) return 32'h1111_1111 * ((a >> 2) + 32'd1);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    always_comb Instruction = mem_word(Address, halt_addr, use_seq);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rn, input logic rv, input logic [31:0] rt,
                              input logic rdy);
        logic [31:0] w;
        if (!rn) begin
            mq.delete();
            m_pc     = RESET_PC;
            m_halted = 1'b0;
            m_fault  = 1'b0;
            m_zero   = 1'b1;
            m_known  = 1'b1;
        end else if (m_known) begin
            if (mq.size() != 0 && rdy) exp_q.push_back(mq.pop_front());
`ifdef ALIGN_CHECK_EN
            if (rv && !m_fault) begin
                mq.delete();
                m_pc = rt;
                if (rt[1:0] != 2'b00) begin
                    m_fault  = 1'b1;
                    m_halted = 1'b1;
                end else begin
                    m_halted = 1'b0;
                end
            end else
`else
            if (rv) begin
                mq.delete();
                m_pc     = rt & 32'hFFFF_FFFC;
                m_halted = 1'b0;
            end else
`endif
            if (!m_halted && mq.size() < 2) begin
                w = mem_word(m_pc, halt_addr, use_seq);
                mq.push_back('{pc: m_pc, instr: w});
                m_zero = 1'b0;
                if (w == HALT_WORD) m_halted = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // One clock of stimulus: expected visible state is queued before the model advances.
    task automatic drive(input logic rn, input logic rv, input logic [31:0] rt, input logic rdy);
        st_t s;
        if (!rn) begin
            rv  = 1'b0;
            rdy = 1'b0;
        end
        Reset_n        = rn;
        RedirectValid  = rv;
        RedirectTarget = rt;
        dec.IfReady    = rdy;
        s.chk       = m_known;
        s.valid     = (mq.size() != 0);
        s.head      = (mq.size() != 0) ? mq[0] : '0;
        s.pc        = m_pc;
        s.halted    = m_halted;
        s.fault     = m_fault;
        s.zero_head = m_zero;
        st_q.push_back(s);
        model_step(rn, rv, rt, rdy);
        @(posedge Clk);
        #1;
    endtask

    always @(negedge Clk) begin
        st_t  s;
        ent_t e;
        if (running) begin
            if (st_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL status_queue: got empty expected an entry");
            end else begin
                s = st_q.pop_front();
                if (s.chk) begin
                    check("IfValid", {31'b0, dec.IfValid}, {31'b0, s.valid});
                    check("Address", Address, s.pc);
                    check("Halted", {31'b0, Halted}, {31'b0, s.halted});
                    check("Fault", {31'b0, Fault}, {31'b0, s.fault});
                    if (s.valid) begin
                        check("IfInstr", dec.IfInstr, s.head.instr);
                        check("IfPC", dec.IfPC, s.head.pc);
                        check("IfPCPlus4", dec.IfPCPlus4, s.head.pc + 32'd4);
                    end else if (s.zero_head) begin
                        check("IfInstr_reset", dec.IfInstr, 32'h0);
                        check("IfPC_reset", dec.IfPC, 32'h0);
                        check("IfPCPlus4_reset", dec.IfPCPlus4, 32'h4);
                    end
                end
            end
            if (dec.IfValid === 1'b1 && dec.IfReady === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pop_unexpected: got pc %h expected no pop", dec.IfPC);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_instr", dec.IfInstr, e.instr);
                    check("pop_pc", dec.IfPC, e.pc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        rn, rv, rdy;
        logic [31:0] rt;
        Reset_n        = 1'b0;
        RedirectValid  = 1'b0;
        RedirectTarget = '0;
        dec.IfReady    = 1'b0;
        halt_addr      = 32'h10;
        use_seq        = 1'b1;

        repeat (2) drive(1'b0, 1'b0, 32'h0, 1'b0);
        // Streaming from reset into the halt word at 0x10, then drain
        repeat (8) drive(1'b1, 1'b0, 32'h0, 1'b1);
        // Restart from halt, stall with a full buffer, release
        drive(1'b1, 1'b1, 32'h0, 1'b0);
        repeat (5) drive(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (4) drive(1'b1, 1'b0, 32'h0, 1'b1);
        // Redirect with a full buffer
        repeat (3) drive(1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 32'h40, 1'b0);
        repeat (4) drive(1'b1, 1'b0, 32'h0, 1'b1);
        // Misaligned redirect, then an aligned one
        drive(1'b1, 1'b1, 32'h42, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 32'h0, 1'b1);
        drive(1'b1, 1'b1, 32'h0, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        // PC wrap, then reset mid-stream
        drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (4) drive(1'b1, 1'b0, 32'h0, 1'b1);

        use_seq = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) halt_addr = 32'($urandom_range(0, 63)) << 2;
            rn  = ($urandom_range(0, 63) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 11) == 0);
            rt  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
            drive(rn, rv, rt, rdy);
        end
        repeat (6) drive(1'b1, 1'b0, 32'h0, 1'b1);

        running = 1'b0;
        check("scoreboard_leftover", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer for the single-cycle/pipelined MIPS datapath. It owns the program counter, drives Address into the combinational InstructionMemory, and captures the returned Instruction into a 2-entry fetch buffer. The buffer feeds decode through a valid/ready handshake. It handles branch/jump redirects, halts on a sentinel word, and restarts on redirect.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops fetching.

Ports:
Clk  input  1  system clock; all state updates on rising edge.
Reset_n  input  1  synchronous reset, active-low.
Address  output  32  byte address to InstructionMemory; equals the PC register.
Instruction  input  32  word returned combinationally by InstructionMemory for Address.
RedirectValid  input  1  branch/jump taken this cycle.
RedirectTarget  input  32  new fetch address, sampled when RedirectValid=1.
IfValid  output  1  buffer head holds a valid instruction.
IfReady  input  1  decode accepts the head this cycle.
IfInstr  output  32  head instruction.
IfPC  output  32  address of the head instruction.
IfPCPlus4  output  32  IfPC+4, modulo 2^32.
Halted  output  1  fetch stopped (HALT state).
Fault  output  1  sticky misaligned-redirect flag; tied 0 unless ALIGN_CHECK_EN.

Behaviour:
- Clock and reset are decided as follows: one clock, Clk. Reset_n is synchronous and active-low.
- Reset (Reset_n=0 at an edge) sets:
  - PC=RESET_PC, buffer count=0, state=RUN.
  - IfValid=0, IfInstr=0, IfPC=0, IfPCPlus4=4, Halted=0, Fault=0.
- Reset applied mid-operation discards all buffered entries and any pending halt.
- States:
  - RUN: fetching.
  - HALT: no capture; PC holds.
- Pop: occurs when IfValid && IfReady at an edge.
  - IfValid = (count != 0).
  - Head outputs are registered buffer contents; they never combine directly from Instruction.
- Capture (RUN only, no redirect):
  - Condition: count<2, or count==2 with a pop in the same cycle.
  - Action: enqueue {PC, Instruction}, then PC <= PC+4.
  - If count==2 and there is no pop, there is no capture and PC holds. Nothing is ever dropped.
- Latency:
  - The first edge with Reset_n=1 captures the word at RESET_PC, so IfValid=1 after that edge.
  - Throughput is 1 instruction/cycle while IfReady=1.
- PC arithmetic:
  - 32-bit, wraps: 32'hFFFFFFFC+4 = 32'h00000000.
  - The PC is always word-aligned in RUN.
- Redirect (RedirectValid=1 at an edge) has top priority over capture, halt and pop:
  - Buffer is flushed (count=0) and PC <= target.
  - There is no capture in the redirect cycle.
  - A pop in the same cycle counts as completed for decode; all remaining entries are discarded.
  - The next edge captures the word at the target, so there is a one-cycle bubble: IfValid=0 for one cycle.
  - A redirect while in HALT returns the block to RUN with the same timing.
- Halt:
  - When a captured Instruction equals HALT_WORD, it is enqueued normally and state becomes HALT.
  - PC = halt address + 4 and holds there.
  - Already-buffered entries, including the halt word, still drain via pops.
  - Halted=1 while in HALT.
  - If a redirect arrives in the same cycle as the halt capture, the redirect wins and state stays RUN.
- Without the optional feature, RedirectTarget[1:0] is ignored and forced to 00.

Optional Feature:
Macro: ALIGN_CHECK_EN.
- With the macro defined, a redirect with RedirectTarget[1:0] != 00 does the following:
  - Flushes the buffer.
  - Sets Fault=1 (sticky until reset) and enters HALT.
  - Sets PC to the unaligned target, held; no fetch is performed.
  - Later redirects are ignored while Fault=1, and only reset clears it.
- Without the macro, Fault is constant 0, and an unaligned target is truncated to word alignment and fetched normally.

Test Plan:
1. Reset, then IfReady=1, with memory words 0x11111111, 0x22222222, 0x33333333, 0x44444444 at 0x0, 0x4, 0x8, 0xC -> IfValid=1 from the first post-reset edge; IfInstr sequence 0x11111111..0x44444444 on consecutive cycles; IfPC 0x0, 0x4, 0x8, 0xC; IfPCPlus4 0x4..0x10.
2. Same memory, IfReady=0 for 5 cycles then 1 -> count saturates at 2; Address holds at 0x8; after release IfPC=0x0, 0x4, 0x8 with no gaps or duplicates.
3. Buffer full, RedirectValid=1 with target 0x40 -> next cycle IfValid=0 and Address=0x40; the cycle after, IfPC=0x40 and IfPCPlus4=0x44.
4. HALT_WORD placed at 0x10, IfReady=1 -> HALT_WORD delivered with IfPC=0x10; Halted=1; Address stays 0x14; IfValid drops after the drain. Then redirect to 0x0 -> Halted=0 and fetch restarts at 0x0.
5. Redirect to 0x42 -> with ALIGN_CHECK_EN: Fault=1, Halted=1, IfValid=0, and a later redirect to 0x0 is ignored. Without the macro: fetch proceeds at 0x40.
6. Redirect to 0xFFFFFFFC, then Reset_n=0 for one edge mid-stream -> before reset IfPC=0xFFFFFFFC then 0x0 (wrap). After reset all outputs take their reset values and the first capture is at RESET_PC.
